// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the multi-cycle data-memory responder.
//   WORD_W     : data word width (32 bits)
//   state_e    : responder FSM states (IDLE, BUSY, DONE)
//   idx_width(): word-index width for a given depth, $clog2(depth) with a floor
//                of 1 so a degenerate depth still yields a legal vector.
// No configuration macros.
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Synchronous single-port word storage with write enable and registered read.
// Reset clears only the read register; stored words are never reset.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (read register only)
//   we_i     : write wdata_i to addr_i at the rising edge
//   re_i     : capture mem[addr_i] into rdata_o at the rising edge
//   addr_i   : word index
//   wdata_i  : write data
//   rdata_o  : registered read data, holds its value when re_i is low
// No configuration macros.
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int IDX_W       = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // Storage kept in its own process without reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data memory for the pipeline MEM stage. Accepts one load/store at
// a time, waits LATENCY cycles, commits the access, then pulses resp_valid_o
// for one cycle. stall_o holds the pipeline while a request is pending.
// Ports:
//   clk_i        : clock
//   rst_i        : synchronous active-high reset (memory contents untouched)
//   req_valid_i  : request present
//   req_we_i     : 1 = store, 0 = load (sampled at acceptance)
//   addr_i       : byte address; word index = addr[IDX_W+1:2]
//   wdata_i      : store data
//   stall_o      : (IDLE & req_valid_i) | BUSY
//   resp_valid_o : one-cycle completion pulse (DONE state)
//   rdata_o      : registered load data
//   err_o        : registered misaligned-access flag, high with resp_valid_o
// Configuration macro: DMEM_MISALIGN_CHK_EN -- when defined, accesses whose
// latched addr[1:0] != 0 run the full sequence but do not touch memory or
// rdata_o, and raise err_o in the DONE cycle. When undefined, err_o is 0 and
// addr[1:0] is ignored.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              resp_valid_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                we_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                resp_q;
  logic                err_q;
  logic                misalign;
  logic                accept;
  logic                commit;
  logic                mem_we;
  logic                mem_re;

  // Bits above the word index (and addr[1:0] when the check is off) are
  // intentionally ignored: addresses wrap modulo DEPTH_WORDS*4.
  logic unused_addr;
  assign unused_addr = ^addr_i;

  assign accept = (state_q == IDLE) && req_valid_i;
  assign commit = (state_q == BUSY) && (cnt_q == '0);

  // Reset gates the write so a store aborted at its commit edge is dropped.
  assign mem_we = commit && we_q && !misalign && !rst_i;
  assign mem_re = commit && !we_q && !misalign;

`ifdef DMEM_MISALIGN_CHK_EN
  logic mis_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= (addr_i[1:0] != 2'b00);
    end
  end
  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          err_q  <= 1'b0;
          if (req_valid_i) begin
            idx_q   <= addr_i[IDX_W+1:2];
            we_q    <= req_we_i;
            wdata_q <= wdata_i;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            // Access happens at this edge (array side); response follows.
            resp_q  <= 1'b1;
            err_q   <= misalign;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // A request seen here waits for the next IDLE cycle.
          resp_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          resp_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata_o)
  );

  assign stall_o      = accept || (state_q == BUSY);
  assign resp_valid_o = resp_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder (DEPTH_WORDS=128, LATENCY=2).
// Directed vector table, hand-written multi-cycle sequences (abort, reset
// priority, back-to-back) and randomized traffic against a word-array model.
// Honours DMEM_MISALIGN_CHK_EN for expected err_o / memory behaviour.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: plain word array plus the last load result.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] rdata_m;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [9];

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .ADDR_W      (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_we_i     (req_we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .stall_o      (stall),
    .resp_valid_o (resp_valid),
    .rdata_o      (rdata),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a);
    bit m;
    m = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    m = (a % 4) != 0;
`endif
    return m;
  endfunction

  function automatic void model_apply(input bit we, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'((a / 4) % DEPTH);
    if (!is_mis(a)) begin
      if (we) mem_m[idx] = d;
      else    rdata_m    = mem_m[idx];
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One full request from an IDLE cycle boundary back to the next IDLE cycle.
  task automatic xact(input string tag, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_err);
    int cyc;
    bit got;
    req_valid = 1'b1;
    req_we    = we;
    addr      = a;
    wdata     = d;
    cyc       = 1;
    got       = 1'b0;
    while (!got && cyc <= 4 * LAT + 8) begin
      #1;
      if (cyc <= LAT + 1) chk({tag, " stall"}, 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      cyc++;
      if (resp_valid) got = 1'b1;
      else begin
        // Request is latched, so later input changes must have no effect.
        req_we = 1'($urandom);
        addr   = $urandom;
        wdata  = $urandom;
      end
    end
    req_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no resp_valid_o within %0d cycles", tag, cyc);
    end else begin
      chk({tag, " latency"}, 32'(cyc), 32'(LAT + 2));
      #1;
      chk({tag, " stall_done"}, 32'(stall), 32'd0);
      chk({tag, " rdata"}, rdata, exp_rd);
      chk({tag, " err"}, 32'(err), 32'(exp_err));
      cycle();
      chk({tag, " resp_drop"}, 32'(resp_valid), 32'd0);
      chk({tag, " err_drop"}, 32'(err), 32'd0);
      chk({tag, " rdata_hold"}, rdata, exp_rd);
    end
    $display("xact %s we=%0d addr=%h wdata=%h rdata=%h err=%0d", tag, we, a, d, rdata, err);
  endtask

  initial begin
    int pulses, first_c, second_c;
    bit          r_we;
    logic [31:0] r_a, r_d;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    addr      = '0;
    wdata     = '0;
    rdata_m   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset resp", 32'(resp_valid), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset err", 32'(err), 32'd0);

    // Directed table: store/load, wrap-around, misalignment.
    tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h204, 32'h1,        32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b0, 32'h004, 32'h0,        32'h1,        1'b0};
    tbl[4] = '{1'b1, 32'h20,  32'h12345678, 32'h1,        1'b0};
`ifdef DMEM_MISALIGN_CHK_EN
    tbl[5] = '{1'b1, 32'h22,  32'h55,       32'h1,        1'b1};
    tbl[6] = '{1'b0, 32'h20,  32'h0,        32'h12345678, 1'b0};
    tbl[7] = '{1'b0, 32'h11,  32'h0,        32'h12345678, 1'b1};
`else
    tbl[5] = '{1'b1, 32'h22,  32'h55,       32'h1,        1'b0};
    tbl[6] = '{1'b0, 32'h20,  32'h0,        32'h55,       1'b0};
    tbl[7] = '{1'b0, 32'h11,  32'h0,        32'hDEADBEEF, 1'b0};
`endif
    tbl[8] = '{1'b0, 32'h210, 32'h0,        32'hDEADBEEF, 1'b0};
    for (int i = 0; i < 9; i++) begin
      model_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      xact($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
           tbl[i].exp_rd, tbl[i].exp_err);
    end

    // Give every word a known value so later loads are fully predictable.
    for (int i = 0; i < DEPTH; i++) begin
      r_d = $urandom;
      model_apply(1'b1, 32'(i * 4), r_d);
      xact("init", 1'b1, 32'(i * 4), r_d, rdata_m, 1'b0);
    end

    // Reset in the second BUSY cycle aborts a store.
    req_valid = 1'b1; req_we = 1'b1; addr = 32'h20; wdata = 32'h55;
    cycle();
    cycle();
    rst = 1'b1; req_valid = 1'b0;
    cycle();
    rst = 1'b0;
    rdata_m = '0;
    #1;
    chk("abort resp", 32'(resp_valid), 32'd0);
    chk("abort stall", 32'(stall), 32'd0);
    chk("abort rdata", rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("abort no_resp", 32'(resp_valid), 32'd0);
    end
    model_apply(1'b0, 32'h20, 32'h0);
    xact("abort_load", 1'b0, 32'h20, 32'h0, rdata_m, 1'b0);

    // Reset wins over a simultaneous request.
    req_valid = 1'b1; req_we = 1'b1; addr = 32'h30; wdata = 32'hFFFF0000; rst = 1'b1;
    cycle();
    req_valid = 1'b0; rst = 1'b0;
    rdata_m = '0;
    #1;
    chk("rstwin stall", 32'(stall), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rstwin no_resp", 32'(resp_valid), 32'd0);
    end
    model_apply(1'b0, 32'h30, 32'h0);
    xact("rstwin_load", 1'b0, 32'h30, 32'h0, rdata_m, 1'b0);

    // Reset during DONE: the store already committed, the pulse is cut.
    req_valid = 1'b1; req_we = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D;
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    chk("rstdone resp", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_apply(1'b1, 32'h40, 32'hCAFEF00D);
    rdata_m = '0;
    chk("rstdone resp_clr", 32'(resp_valid), 32'd0);
    chk("rstdone rdata", rdata, 32'd0);
    model_apply(1'b0, 32'h40, 32'h0);
    xact("rstdone_load", 1'b0, 32'h40, 32'h0, rdata_m, 1'b0);

    // Back-to-back: req held high across two loads.
    pulses = 0; first_c = 0; second_c = 0;
    req_valid = 1'b1; req_we = 1'b0; addr = 32'h44;
    for (int c = 1; c <= 12; c++) begin
      if (c == 6) req_valid = 1'b0;
      #1;
      if (c == 4) chk("b2b stall_done", 32'(stall), 32'd0);
      if (c == 5) chk("b2b stall_accept", 32'(stall), 32'd1);
      if (resp_valid) begin
        pulses++;
        if (pulses == 1) first_c = c;
        else if (pulses == 2) second_c = c;
      end
      cycle();
    end
    model_apply(1'b0, 32'h44, 32'h0);
    chk("b2b pulses", 32'(pulses), 32'd2);
    chk("b2b first", 32'(first_c), 32'd4);
    chk("b2b second", 32'(second_c), 32'd8);
    chk("b2b rdata", rdata, rdata_m);
    $display("b2b pulses=%0d at cycles %0d,%0d", pulses, first_c, second_c);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      r_we = 1'($urandom);
      r_a  = $urandom;
      if ($urandom_range(3) != 0) r_a[1:0] = 2'b00;
      r_d  = $urandom;
      model_apply(r_we, r_a, r_d);
      xact("rand", r_we, r_a, r_d, rdata_m, is_mis(r_a));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
